// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and helpers for the UART transmitter
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DATA_BITS = 8;

  // Clock cycles spent on each bit on the line
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period timer, phase-aligned to the start of enable
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..CLKS_PER_BIT-1 while enabled; held at zero otherwise so each frame starts a fresh bit period
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!enable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Tick marks the final clock of the current bit period
  assign bit_tick = enable && (cnt == LAST);

endmodule

// File: rtl/uart_tx_top.sv
// rtl/uart_tx_top.sv - 8N1 UART transmitter with internal baud timing
module uart_tx_top
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       tx,
  output logic       busy
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_top: CLKS_PER_BIT must be at least 2");
    end
  endgenerate

  uart_state_t          state;
  logic [DATA_BITS-1:0] shift;
  logic [IDX_W-1:0]     bit_idx;
  logic                 bit_tick;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk     (clk),
    .reset   (reset),
    .enable  (state != IDLE),
    .bit_tick(bit_tick)
  );

  // Frame sequencer; tx and busy are computed one edge ahead so they come straight from flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (data_valid) begin
            shift <= data_in;
            state <= START;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (bit_tick) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shift[0];
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx == LAST_IDX) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift[1];
            end
          end
        end
        STOP: begin
          if (bit_tick) begin
            state <= IDLE;
            busy  <= 1'b0;
            tx    <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_top.sv
// tb/tb_uart_tx_top.sv - directed vector bench for the 8N1 UART transmitter
module tb_uart_tx_top;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       tx;
  logic       busy;

  int n_vec = 0;
  int n_bad = 0;

  uart_tx_top #(
    .CLK_FREQ (100_000_000),
    .BAUD_RATE(10_000_000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .data_valid(data_valid),
    .tx        (tx),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] exp_frame;  // bit i = expected line level during bit period i (start first)
    logic [7:0] exp_byte;
    int         gap;        // idle clocks after the frame
  } vec_t;

  vec_t vecs [3];

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic check_idle(input string nm);
    check({nm, " tx"}, int'(tx), 1);
    check({nm, " busy"}, int'(busy), 0);
  endtask

  // Called at the first negedge after acceptance; leaves off at the frame's last cycle
  task automatic check_frame(input string nm, input logic [9:0] exp_frame, input logic [7:0] exp_byte,
                             input int inj_k, input logic [7:0] inj_d, input int clr_k);
    int         errs [10];
    int         busy_cnt;
    logic [7:0] dec;
    busy_cnt = 0;
    dec = '0;
    for (int b = 0; b < 10; b++) errs[b] = 0;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) @(negedge clk);
      if (k == inj_k) begin
        data_in    = inj_d;
        data_valid = 1'b1;
      end
      if (k == clr_k) data_valid = 1'b0;
      if (tx !== exp_frame[k / 10]) errs[k / 10]++;
      if (busy === 1'b1) busy_cnt++;
      if ((k % 10) == 5 && (k / 10) >= 1 && (k / 10) <= 8) dec[(k / 10) - 1] = tx;
    end
    for (int b = 0; b < 10; b++)
      check($sformatf("%s tx level bit%0d wrong-samples", nm, b), errs[b], 0);
    check({nm, " busy clocks"}, busy_cnt, 100);
    check({nm, " decoded byte"}, int'(dec), int'(exp_byte));
  endtask

  initial begin
    int bad;
    vecs[0] = '{data: 8'hAA, exp_frame: 10'h354, exp_byte: 8'hAA, gap: 101};
    vecs[1] = '{data: 8'hCC, exp_frame: 10'h398, exp_byte: 8'hCC, gap: 5};
    vecs[2] = '{data: 8'h0F, exp_frame: 10'h21E, exp_byte: 8'h0F, gap: 5};

    // Reset held with a pending strobe: line must stay idle
    reset      = 1'b0;
    data_valid = 1'b1;
    data_in    = 8'hAA;
    repeat (2) begin
      @(negedge clk);
      check_idle("in reset");
    end
    reset      = 1'b1;
    data_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_idle("after reset");

    // Table-driven single frames
    foreach (vecs[i]) begin
      @(negedge clk);
      check_idle($sformatf("vec%0d strobe cycle", i));
      data_in    = vecs[i].data;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      check_frame($sformatf("vec%0d", i), vecs[i].exp_frame, vecs[i].exp_byte, -1, 8'h00, -1);
      @(negedge clk);
      check_idle($sformatf("vec%0d end", i));
      repeat (vecs[i].gap) @(negedge clk);
    end

    // Strobe while busy is ignored
    @(negedge clk);
    data_in    = 8'h55;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    check_frame("reject", 10'h2AA, 8'h55, 30, 8'hFF, 31);
    @(negedge clk);
    check_idle("reject end");
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("reject no second frame", bad, 0);

    // Back-to-back with data_valid held high
    @(negedge clk);
    data_in    = 8'h01;
    data_valid = 1'b1;
    @(negedge clk);
    check_frame("b2b first", 10'h202, 8'h01, 50, 8'h80, -1);
    @(negedge clk);
    check_idle("b2b gap");
    @(negedge clk);
    check_frame("b2b second", 10'h300, 8'h80, -1, 8'h00, 5);
    @(negedge clk);
    check_idle("b2b end");
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("b2b no third frame", bad, 0);

    // Reset in the middle of a frame
    @(negedge clk);
    data_in    = 8'h00;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (45) @(negedge clk);
    check("midreset busy before", int'(busy), 1);
    check("midreset tx before", int'(tx), 0);
    #1 reset = 1'b0;
    #1;
    check_idle("midreset async");
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    repeat (120) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("midreset no resume", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_top.md
Name: uart_tx_top

Overview:
- 8N1 UART transmitter: 1 start bit, 8 data bits LSB first, no parity, 1 stop bit.
- The baud timing generator is internal to the block.
- It accepts a byte on a single-cycle valid strobe, serialises it on `tx`, and holds `busy` high while the frame is in flight.
- It sits between a local byte producer (CPU/FIFO) and the board-level serial pin.

Parameters:
- CLK_FREQ, 100_000_000 — system clock frequency in Hz.
- BAUD_RATE, 10_000_000 — line bit rate in bits/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (10) — derived localparam, clock cycles per bit. It must be at least 2; elaboration fails otherwise.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- data_in  input  8  byte to transmit; sampled only on an accepted strobe.
- data_valid  input  1  transmit request strobe.
- tx  output  1  serial line; idle level is 1.
- busy  output  1  high while a frame is being transmitted.

Behaviour:
- Reset (reset==0, asynchronous):
  - FSM goes to IDLE.
  - tx=1, busy=0.
  - Shift register, bit index and baud counter are cleared.
  - Reset mid-frame aborts the frame immediately; tx returns to 1 with no partial stop bit.
- FSM states:
  - IDLE: tx=1, busy=0.
  - START: tx=0.
  - DATA: tx=shift[0].
  - STOP: tx=1.
- Acceptance:
  - A byte is accepted on a rising clock edge where the FSM is in IDLE and data_valid==1.
  - On that edge data_in is latched into the shift register, the FSM enters START, and busy goes to 1.
  - So tx falls and busy rises one cycle after the strobe cycle (latency 1 clock).
- Bit timing:
  - The baud counter is cleared on acceptance and counts 0..CLKS_PER_BIT-1.
  - The internal bit tick fires when the count equals CLKS_PER_BIT-1.
  - Every bit, including start and stop, lasts exactly CLKS_PER_BIT clocks.
  - The counter only runs while not in IDLE, so frames are phase-aligned to acceptance, not to a free-running tick.
- Transitions on tick:
  - START→DATA, with bit index=0.
  - In DATA: shift right, increment index; after the 8th data bit go to STOP.
  - STOP→IDLE.
- busy deasserts on the edge STOP→IDLE. A full frame occupies 10*CLKS_PER_BIT clocks with busy=1.
- The data_valid level is irrelevant outside IDLE:
  - Strobes while busy=1 are ignored, not queued.
  - data_in changes while busy do not affect the frame in flight.
- Back-to-back: data_valid held or asserted in the first IDLE cycle after STOP is accepted. Minimum gap between frames is 1 idle clock at tx=1.
- Outputs tx and busy are registered (glitch-free).

Decomposition:
- Shared package uart_pkg:
  - state enum typedef (IDLE, START, DATA, STOP);
  - DATA_BITS=8;
  - helper function computing CLKS_PER_BIT.
- One sub-module: uart_baud_gen. It takes clk, reset and an enable, and emits a one-cycle bit_tick every CLKS_PER_BIT clocks. The counter clears whenever enable is 0.
- The top holds the FSM and the shift register.

Test Plan:
- Reset: hold reset=0 for 2 clocks with data_valid=1 → tx=1 and busy=0 throughout. After release with data_valid=0, the line stays idle.
- Single frame 0xAA:
  - Strobe data_valid for 1 clock.
  - tx must read 0 (start), then 0,1,0,1,0,1,0,1, then stop bit 1.
  - Each level holds exactly 10 clocks.
  - busy=1 for exactly 100 clocks, starting 1 clock after the strobe.
- Second frame 0xCC, after 102 idle clocks → tx reads 0 (start), then 0,0,1,1,0,0,1,1, then 1 (stop), 10 clocks each. The decoded byte equals 0xCC.
- Busy rejection:
  - Send 0x55, then pulse data_valid with data_in=0xFF at clock 30 of the frame.
  - The frame still decodes to 0x55.
  - busy falls at clock 100 and no second frame starts.
- Back-to-back: keep data_valid=1 continuously with 0x01 then 0x80 → two frames decoding to 0x01 and 0x80, separated by exactly 1 idle clock at tx=1.
- Reset mid-frame: assert reset at clock 45 of a 0x00 frame → tx=1 and busy=0 immediately, asynchronously. After release with data_valid=0, no frame resumes.
